// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: NUM_DIGITS cascaded BCD digits advanced by an
// internal tick prescaler, with an IDLE/RUN/PAUSE FSM driven by single-cycle
// button pulses and a one-cycle wrap strobe.
// Optional lap-hold display: define STOPWATCH_LAP_EN to build it.
//
// Button inputs are single-cycle pulses sampled on posedge clk; there is no
// valid/ready handshake. Every output is registered or decoded from a register.
module stopwatch_bcd_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_run_stop,
    input  logic                    i_clear,
    input  logic                    i_lap,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_running,
    output logic                    o_wrap,
    output logic                    o_lap_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    logic          clear_hit;
    logic          carry;
    logic [3:0]    dig;

    // Tick fires on the last prescaler cycle of RUN; clear only acts in PAUSE.
    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign clear_hit = (state_q == ST_PAUSE) && i_clear;

    // FSM next state; in PAUSE a simultaneous clear beats run/stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_run_stop) state_d = ST_RUN;
            ST_RUN:   if (i_run_stop) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (i_clear)         state_d = ST_IDLE;
                else if (i_run_stop) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Prescaler: advances in RUN, holds in PAUSE, zero in IDLE or on clear.
    always_comb begin
        presc_d = presc_q;
        if (state_q == ST_IDLE || clear_hit) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // BCD increment with a combinational carry ripple; carry out of the top
    // digit is the wrap condition. The tick is applied even on the edge that
    // moves RUN to PAUSE, since it is decoded from the current state.
    always_comb begin
        count_d = count_q;
        carry   = tick;
        dig     = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (dig >= 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        wrap_d = carry;
        if (state_q == ST_IDLE || clear_hit) begin
            count_d = '0;
            wrap_d  = 1'b0;
        end
    end

    // Core state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_running = (state_q == ST_RUN);
    assign o_wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic [BW-1:0] lap_q;
    logic          lap_active_q;

    // Lap hold: capture the live count in RUN, release on the next lap pulse
    // in any state, and always drop the hold when a clear returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q        <= '0;
            lap_active_q <= 1'b0;
        end else if (clear_hit) begin
            lap_active_q <= 1'b0;
        end else if (i_lap && lap_active_q) begin
            lap_active_q <= 1'b0;
        end else if (i_lap && state_q == ST_RUN) begin
            lap_q        <= count_q;
            lap_active_q <= 1'b1;
        end
    end

    assign o_bcd        = lap_active_q ? lap_q : count_q;
    assign o_lap_active = lap_active_q;
`else
    logic unused_lap;
    assign unused_lap   = i_lap;
    assign o_bcd        = count_q;
    assign o_lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: instance A (4 digits, TICK_DIV=4) and
// instance B (2 digits, TICK_DIV=1) share clock and reset.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_stopwatch_bcd_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_run = 1'b0, a_clr = 1'b0, a_lap = 1'b0;
    logic [15:0] a_bcd;
    logic        a_running, a_wrap, a_lapact;
    logic        b_run = 1'b0, b_clr = 1'b0, b_lap = 1'b0;
    logic [7:0]  b_bcd;
    logic        b_running, b_wrap, b_lapact;

    int n_cmp = 0;
    int n_err = 0;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    stopwatch_bcd_counter #(.NUM_DIGITS(4), .TICK_DIV(4)) dut_a (
        .clk(clk), .reset(reset),
        .i_run_stop(a_run), .i_clear(a_clr), .i_lap(a_lap),
        .o_bcd(a_bcd), .o_running(a_running), .o_wrap(a_wrap),
        .o_lap_active(a_lapact)
    );

    stopwatch_bcd_counter #(.NUM_DIGITS(2), .TICK_DIV(1)) dut_b (
        .clk(clk), .reset(reset),
        .i_run_stop(b_run), .i_clear(b_clr), .i_lap(b_lap),
        .o_bcd(b_bcd), .o_running(b_running), .o_wrap(b_wrap),
        .o_lap_active(b_lapact)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_run = 1'b0; a_clr = 1'b0; a_lap = 1'b0;
        b_run = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Drivers: one-cycle pulses covering exactly one posedge.
    task automatic pulse_a(input logic run, input logic clr, input logic lap);
        a_run = run; a_clr = clr; a_lap = lap;
        step(1);
        a_run = 1'b0; a_clr = 1'b0; a_lap = 1'b0;
    endtask

    task automatic pulse_b(input logic run);
        b_run = run;
        step(1);
        b_run = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (a_bcd !== 16'h0000) begin n_err++; $display("FAIL reset_a_bcd got %h want 0000", a_bcd); end
        n_cmp++; if (a_running !== 1'b0) begin n_err++; $display("FAIL reset_a_running got %b want 0", a_running); end
        n_cmp++; if (a_wrap !== 1'b0) begin n_err++; $display("FAIL reset_a_wrap got %b want 0", a_wrap); end
        n_cmp++; if (a_lapact !== 1'b0) begin n_err++; $display("FAIL reset_a_lap got %b want 0", a_lapact); end
        n_cmp++; if (b_bcd !== 8'h00) begin n_err++; $display("FAIL reset_b_bcd got %h want 00", b_bcd); end
        // Clear in IDLE does nothing.
        pulse_a(1'b0, 1'b1, 1'b0);
        step(3);
        n_cmp++; if (a_running !== 1'b0 || a_bcd !== 16'h0000) begin n_err++; $display("FAIL idle_clear got run=%b bcd=%h want 0/0000", a_running, a_bcd); end
    endtask

    task automatic test_count();
        int wraps;
        do_reset();
        pulse_a(1'b1, 1'b0, 1'b0);
        n_cmp++; if (a_running !== 1'b1) begin n_err++; $display("FAIL count_running_entry got %b want 1", a_running); end
        wraps = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (a_wrap) wraps++;
            if (i == 3) begin
                n_cmp++; if (a_bcd !== 16'h0000) begin n_err++; $display("FAIL count_pre_tick got %h want 0000", a_bcd); end
            end
            if (i == 4) begin
                n_cmp++; if (a_bcd !== 16'h0001) begin n_err++; $display("FAIL count_first_tick got %h want 0001", a_bcd); end
            end
        end
        n_cmp++; if (a_bcd !== 16'h0010) begin n_err++; $display("FAIL count_40 got %h want 0010", a_bcd); end
        n_cmp++; if (a_running !== 1'b1) begin n_err++; $display("FAIL count_running got %b want 1", a_running); end
        n_cmp++; if (wraps !== 0) begin n_err++; $display("FAIL count_no_wrap got %0d want 0", wraps); end
    endtask

    task automatic test_wrap();
        int wraps;
        do_reset();
        pulse_b(1'b1);
        wraps = 0;
        for (int i = 1; i <= 99; i++) begin
            step(1);
            if (b_wrap) wraps++;
            if (i == 9) begin
                n_cmp++; if (b_bcd !== 8'h09) begin n_err++; $display("FAIL wrap_09 got %h want 09", b_bcd); end
            end
            if (i == 10) begin
                n_cmp++; if (b_bcd !== 8'h10) begin n_err++; $display("FAIL wrap_carry10 got %h want 10", b_bcd); end
            end
        end
        n_cmp++; if (b_bcd !== 8'h99) begin n_err++; $display("FAIL wrap_99 got %h want 99", b_bcd); end
        n_cmp++; if (wraps !== 0) begin n_err++; $display("FAIL wrap_early got %0d want 0", wraps); end
        step(1);
        n_cmp++; if (b_bcd !== 8'h00 || b_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_edge got bcd=%h wrap=%b want 00/1", b_bcd, b_wrap); end
        step(1);
        n_cmp++; if (b_bcd !== 8'h01 || b_wrap !== 1'b0) begin n_err++; $display("FAIL wrap_after got bcd=%h wrap=%b want 01/0", b_bcd, b_wrap); end
    endtask

    task automatic test_pause_resume();
        int bad;
        do_reset();
        pulse_a(1'b1, 1'b0, 1'b0);      // enters RUN, prescaler 0
        step(5);                         // count 1, prescaler 1
        pulse_a(1'b1, 1'b0, 1'b0);      // pause with prescaler at 2
        n_cmp++; if (a_running !== 1'b0 || a_bcd !== 16'h0001) begin n_err++; $display("FAIL pause_entry got run=%b bcd=%h want 0/0001", a_running, a_bcd); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (a_bcd !== 16'h0001) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pause_hold got %0d bad cycles want 0", bad); end
        pulse_a(1'b1, 1'b0, 1'b0);      // resume edge
        n_cmp++; if (a_running !== 1'b1 || a_bcd !== 16'h0001) begin n_err++; $display("FAIL resume_edge got run=%b bcd=%h want 1/0001", a_running, a_bcd); end
        step(1);
        n_cmp++; if (a_bcd !== 16'h0001) begin n_err++; $display("FAIL resume_plus1 got %h want 0001", a_bcd); end
        step(1);
        n_cmp++; if (a_bcd !== 16'h0002) begin n_err++; $display("FAIL resume_plus2 got %h want 0002", a_bcd); end
    endtask

    task automatic test_clear();
        do_reset();
        pulse_a(1'b1, 1'b0, 1'b0);
        step(20);
        n_cmp++; if (a_bcd !== 16'h0005) begin n_err++; $display("FAIL clear_pre got %h want 0005", a_bcd); end
        pulse_a(1'b0, 1'b1, 1'b0);      // clear in RUN is ignored
        n_cmp++; if (a_running !== 1'b1 || a_bcd !== 16'h0005) begin n_err++; $display("FAIL clear_in_run got run=%b bcd=%h want 1/0005", a_running, a_bcd); end
        step(3);
        n_cmp++; if (a_bcd !== 16'h0006) begin n_err++; $display("FAIL clear_keeps_counting got %h want 0006", a_bcd); end
        pulse_a(1'b1, 1'b1, 1'b0);      // both in RUN: pause, clear ignored
        n_cmp++; if (a_running !== 1'b0 || a_bcd !== 16'h0006) begin n_err++; $display("FAIL both_in_run got run=%b bcd=%h want 0/0006", a_running, a_bcd); end
        pulse_a(1'b1, 1'b1, 1'b0);      // both in PAUSE: clear wins
        n_cmp++; if (a_running !== 1'b0 || a_bcd !== 16'h0000) begin n_err++; $display("FAIL both_in_pause got run=%b bcd=%h want 0/0000", a_running, a_bcd); end
        step(8);
        n_cmp++; if (a_running !== 1'b0 || a_bcd !== 16'h0000) begin n_err++; $display("FAIL idle_stays got run=%b bcd=%h want 0/0000", a_running, a_bcd); end
        pulse_a(1'b1, 1'b1, 1'b0);      // both in IDLE: start
        n_cmp++; if (a_running !== 1'b1) begin n_err++; $display("FAIL both_in_idle got %b want 1", a_running); end
        step(4);                         // prescaler was zeroed by the clear
        n_cmp++; if (a_bcd !== 16'h0001) begin n_err++; $display("FAIL restart_count got %h want 0001", a_bcd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_a(1'b1, 1'b0, 1'b0);
        step(492);
        n_cmp++; if (a_bcd !== 16'h0123) begin n_err++; $display("FAIL areset_pre got %h want 0123", a_bcd); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (a_bcd !== 16'h0000 || a_running !== 1'b0 || a_wrap !== 1'b0 || a_lapact !== 1'b0) begin
            n_err++; $display("FAIL areset_immediate got bcd=%h run=%b wrap=%b lap=%b want 0000/0/0/0", a_bcd, a_running, a_wrap, a_lapact);
        end
        step(2);
        reset = 1'b0;
        step(3);
        n_cmp++; if (a_running !== 1'b0 || a_bcd !== 16'h0000) begin n_err++; $display("FAIL areset_idle got run=%b bcd=%h want 0/0000", a_running, a_bcd); end
        pulse_a(1'b1, 1'b0, 1'b0);
        step(4);
        n_cmp++; if (a_bcd !== 16'h0001 || a_running !== 1'b1) begin n_err++; $display("FAIL areset_restart got run=%b bcd=%h want 1/0001", a_running, a_bcd); end
    endtask

    task automatic test_lap();
        do_reset();
        pulse_a(1'b1, 1'b0, 1'b0);
        step(28);                        // count 7
        pulse_a(1'b0, 1'b0, 1'b1);      // capture
        n_cmp++; if (a_bcd !== 16'h0007 || a_lapact !== LAP_ON) begin n_err++; $display("FAIL lap_capture got bcd=%h lap=%b want 0007/%b", a_bcd, a_lapact, LAP_ON); end
        step(11);                        // three more ticks: live count 0010
        n_cmp++; if (a_bcd !== (LAP_ON ? 16'h0007 : 16'h0010)) begin n_err++; $display("FAIL lap_frozen got %h want %h", a_bcd, (LAP_ON ? 16'h0007 : 16'h0010)); end
        pulse_a(1'b0, 1'b0, 1'b1);      // release
        n_cmp++; if (a_bcd !== 16'h0010 || a_lapact !== 1'b0) begin n_err++; $display("FAIL lap_release got bcd=%h lap=%b want 0010/0", a_bcd, a_lapact); end
        pulse_a(1'b0, 1'b0, 1'b1);      // capture again
        n_cmp++; if (a_lapact !== LAP_ON) begin n_err++; $display("FAIL lap_recapture got %b want %b", a_lapact, LAP_ON); end
        pulse_a(1'b1, 1'b0, 1'b0);      // pause with hold active
        n_cmp++; if (a_lapact !== LAP_ON || a_running !== 1'b0) begin n_err++; $display("FAIL lap_pause got lap=%b run=%b want %b/0", a_lapact, a_running, LAP_ON); end
        pulse_a(1'b0, 1'b1, 1'b0);      // clear drops the hold
        n_cmp++; if (a_lapact !== 1'b0 || a_bcd !== 16'h0000) begin n_err++; $display("FAIL lap_clear got lap=%b bcd=%h want 0/0000", a_lapact, a_bcd); end
        pulse_a(1'b0, 1'b0, 1'b1);      // lap in IDLE without hold: ignored
        n_cmp++; if (a_lapact !== 1'b0) begin n_err++; $display("FAIL lap_idle got %b want 0", a_lapact); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause_resume();
        test_clear();
        test_async_reset();
        test_lap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
